// File: rtl/mutex_arb_pkg.sv
// rtl/mutex_arb_pkg.sv - shared types and defaults for the mutex grant front end
package mutex_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SETTLE,
        HOLD,
        RELEASE
    } state_t;

    localparam int CLI0 = 0;
    localparam int CLI1 = 1;

    localparam int SETTLE_CYC_DEF = 2;
    localparam int BREAK_CYC_DEF  = 4;
    localparam int HOLD_MAX_DEF   = 255;

    function automatic logic grant_valid(input logic [1:0] y);
        return y[1] ^ y[0];
    endfunction

    function automatic logic [1:0] onehot(input logic i);
        return (i == 1'(CLI1)) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/grant_stability_filter.sv
// rtl/grant_stability_filter.sv - tracks a run of identical one-hot grant samples
module grant_stability_filter
    import mutex_arb_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mx_y,
    input  logic       start,
    input  logic       advance,
    output logic       valid,
    output logic       idx,
    output logic       same,
    output logic       first_last,
    output logic       last
);

    localparam logic [4:0] SETTLE_T = 5'(SETTLE_CYC);

    logic [1:0] g;
    logic [3:0] scnt;
    logic [4:0] scnt_inc;

    assign valid      = grant_valid(mx_y);
    assign idx        = mx_y[1];
    assign same       = (mx_y == g);
    assign scnt_inc   = {1'b0, scnt} + 5'd1;
    assign first_last = (SETTLE_T <= 5'd1);
    assign last       = (scnt_inc >= SETTLE_T);

    // Any cycle that neither starts nor extends the run breaks it.
    always_ff @(posedge clk) begin
        if (rst) begin
            g    <= '0;
            scnt <= '0;
        end else if (start) begin
            g    <= mx_y;
            scnt <= 4'd1;
        end else if (advance) begin
            scnt <= scnt_inc[3:0];
        end else begin
            scnt <= '0;
        end
    end

endmodule

// File: rtl/mutex_grant_ctrl.sv
// rtl/mutex_grant_ctrl.sv - four-phase req/ack front end for a two-client NAND mutex
module mutex_grant_ctrl
    import mutex_arb_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int BREAK_CYC  = BREAK_CYC_DEF,
    parameter int HOLD_MAX   = HOLD_MAX_DEF,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] ack,
    output logic [1:0] mx_x,
    input  logic [1:0] mx_y,
    output logic       busy,
    output logic       timeout,
    output logic       timeout_id
);

    localparam logic [3:0]       BREAK_T = 4'(BREAK_CYC);
    localparam logic [CNT_W-1:0] HOLD_T  = CNT_W'(HOLD_MAX);

    state_t           state;
    logic             w;
    logic             rr;
    logic             mask_id;
    logic             mask_rem;
    logic             fired;
    logic [3:0]       wcnt;
    logic [CNT_W-1:0] hcnt;
    logic [1:0]       fwd;

    logic g_valid, g_idx, g_same, g_first_last, g_last;
    logic f_start, f_adv;

    assign busy    = (state != IDLE);
    assign f_start = (state == WAIT) && g_valid && req[g_idx];
    assign f_adv   = (state == SETTLE) && req[w] && g_same;

    grant_stability_filter #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .mx_y      (mx_y),
        .start     (f_start),
        .advance   (f_adv),
        .valid     (g_valid),
        .idx       (g_idx),
        .same      (g_same),
        .first_last(g_first_last),
        .last      (g_last)
    );

    // The releasing owner stays off the mutex until its grant has dropped.
    always_comb begin
        fwd = req;
        if (mask_rem)
            fwd[mask_id] = 1'b0;
        if (state == RELEASE)
            fwd[w] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ack        <= '0;
            mx_x       <= '0;
            timeout    <= 1'b0;
            timeout_id <= 1'b0;
            w          <= 1'b0;
            rr         <= 1'b0;
            mask_id    <= 1'b0;
            mask_rem   <= 1'b0;
            fired      <= 1'b0;
            wcnt       <= '0;
            hcnt       <= '0;
        end else begin
            mx_x     <= fwd;
            timeout  <= 1'b0;
            mask_rem <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req)
                        state <= WAIT;
                end
                WAIT: begin
                    if (f_start) begin
                        w    <= g_idx;
                        wcnt <= '0;
                        if (g_first_last) begin
                            state <= HOLD;
                            ack   <= onehot(g_idx);
                        end else begin
                            state <= SETTLE;
                        end
                    end else if (req == 2'b00) begin
                        state <= IDLE;
                        wcnt  <= '0;
                    end else if (mx_x == 2'b11 && !g_valid) begin
                        // Persistent tie: drop the non-preferred client for two cycles.
                        if (wcnt + 4'd1 == BREAK_T) begin
                            wcnt       <= '0;
                            mask_id    <= ~rr;
                            mask_rem   <= 1'b1;
                            mx_x[~rr]  <= 1'b0;
                        end else begin
                            wcnt <= wcnt + 4'd1;
                        end
                    end else begin
                        wcnt <= '0;
                    end
                end
                SETTLE: begin
                    if (!req[w]) begin
                        state <= RELEASE;
                    end else if (!g_same) begin
                        state <= WAIT;
                    end else if (g_last) begin
                        state <= HOLD;
                        ack   <= onehot(w);
                    end
                end
                HOLD: begin
                    if (!req[w]) begin
                        state <= RELEASE;
                        ack   <= '0;
                    end else begin
                        if (hcnt != '1)
                            hcnt <= hcnt + 1'b1;
                        if (HOLD_MAX != 0 && !fired && (hcnt + 1'b1) == HOLD_T) begin
                            timeout    <= 1'b1;
                            timeout_id <= w;
                            fired      <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (!mx_y[w]) begin
                        rr    <= ~w;
                        hcnt  <= '0;
                        fired <= 1'b0;
                        state <= (|req) ? WAIT : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mutex_grant_ctrl.sv
// tb/tb_mutex_grant_ctrl.sv - scoreboard bench pairing the controller with a NAND mutex model
module tb_mutex_grant_ctrl;

    localparam int SETTLE = 2;
    localparam int BRK    = 4;
    localparam int HMAX   = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] ack;
    logic [1:0] mx_x;
    logic [1:0] mx_y;
    logic       busy;
    logic       timeout;
    logic       timeout_id;

    logic       n1, n0;
    logic       force_en;
    logic [1:0] force_y;

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;

    typedef struct {
        logic c;
        int   lo;
        int   hi;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mutex_grant_ctrl #(
        .SETTLE_CYC(SETTLE),
        .BREAK_CYC (BRK),
        .HOLD_MAX  (HMAX),
        .CNT_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .mx_x      (mx_x),
        .mx_y      (mx_y),
        .busy      (busy),
        .timeout   (timeout),
        .timeout_id(timeout_id)
    );

    // Cross-coupled registered NANDs: grants are the inverted latch outputs.
    always @(posedge clk) begin
        if (rst) begin
            n1 <= 1'b1;
            n0 <= 1'b1;
        end else begin
            n1 <= ~(mx_x[1] & n0);
            n0 <= ~(mx_x[0] & n1);
        end
    end
    assign mx_y = force_en ? force_y : {~n1, ~n0};

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic [1:0] oh(input logic c);
        return c ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic push(input logic c, input int lo, input int hi);
        exp_t e;
        e.c  = c;
        e.lo = lo;
        e.hi = hi;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input logic c, input int bound);
        int i = 0;
        while (!ack[c] && i < bound) begin
            tick(1);
            i++;
        end
        n_vec++;
        if (!ack[c]) begin
            n_err++;
            $display("FAIL ack_wait: client %0d got no ack within %0d cycles", c, bound);
        end
    endtask

    task automatic wait_idle(input int bound);
        int i = 0;
        while (busy && i < bound) begin
            tick(1);
            i++;
        end
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: pops the expected grant on every ack rise and checks invariants each cycle.
    initial begin
        logic [1:0] prev = 2'b00;
        logic [1:0] rise;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            n_vec++;
            if (ack == 2'b11) begin
                n_err++;
                $display("FAIL ack_onehot: ack=%b required at most one bit", ack);
            end
            rise = ack & ~prev;
            if (rise != 2'b00) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL grant_sb: unexpected ack rise %b at edge %0d", rise, edge_n);
                end else begin
                    e = exp_q.pop_front();
                    if (rise != oh(e.c) || edge_n < e.lo || edge_n > e.hi || (req & rise) != rise) begin
                        n_err++;
                        $display("FAIL grant_sb: ack rise %b at edge %0d req=%b, required client %0d in edges [%0d,%0d]",
                                 rise, edge_n, req, e.c, e.lo, e.hi);
                    end
                end
            end
            prev = ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic uncontested(input logic c);
        int k;
        k = edge_n;
        push(c, k + 4, k + 4);
        req[c] = 1'b1;
        tick(1);
        check("unc_mx_x", {30'd0, mx_x}, {30'd0, oh(c)});
        wait_ack(c, 8);
        tick(2);
        req[c] = 1'b0;
        tick(1);
        check("rel_ack", {30'd0, ack}, 32'd0);
        check("rel_mx_x", {30'd0, mx_x}, 32'd0);
        wait_idle(2);
        tick(2);
    endtask

    task automatic simultaneous(input logic win);
        int k;
        k = edge_n;
        push(win, k + 1 + BRK + SETTLE, k + 1 + BRK + SETTLE + 6);
        req = 2'b11;
        wait_ack(win, 30);
        tick(3);
        check("contest_mx_x", {30'd0, mx_x}, 32'd3);
        check("contest_ack", {30'd0, ack}, {30'd0, oh(win)});
        k = edge_n;
        push(~win, k + 1 + 2 + SETTLE, k + 1 + 2 + SETTLE + 3);
        req[win] = 1'b0;
        tick(1);
        check("handover_ack0", {30'd0, ack}, 32'd0);
        wait_ack(~win, 12);
        tick(2);
        req[~win] = 1'b0;
        tick(1);
        wait_idle(2);
        tick(2);
    endtask

    initial begin
        int k, pulses, pos;
        logic ack_ok, c, contend;
        int h;

        rst = 1'b1;
        req = 2'b00;
        force_en = 1'b0;
        force_y = 2'b00;
        tick(3);
        check("reset_ack", {30'd0, ack}, 32'd0);
        check("reset_mx_x", {30'd0, mx_x}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_timeout", {31'd0, timeout}, 32'd0);
        check("reset_timeout_id", {31'd0, timeout_id}, 32'd0);
        rst = 1'b0;
        tick(2);

        uncontested(1'b0);
        uncontested(1'b1);
        simultaneous(1'b0);
        uncontested(1'b0);
        simultaneous(1'b1);

        // Grant glitch during settling restarts the stability run.
        k = edge_n;
        push(1'b0, k + 5, k + 5);
        req = 2'b01;
        tick(1);
        force_en = 1'b1;
        force_y = 2'b01;
        tick(1);
        force_y = 2'b00;
        tick(1);
        force_y = 2'b01;
        tick(2);
        force_en = 1'b0;
        check("glitch_ack", {30'd0, ack}, 32'd1);
        req = 2'b00;
        tick(1);
        wait_idle(2);
        tick(2);

        // Long hold by client 1 produces exactly one timeout pulse.
        k = edge_n;
        push(1'b1, k + 4, k + 4);
        req = 2'b10;
        wait_ack(1'b1, 8);
        pulses = 0;
        pos = -1;
        ack_ok = 1'b1;
        for (int j = 0; j < 20; j++) begin
            if (timeout) begin
                pulses++;
                pos = j;
            end
            if (ack != 2'b10)
                ack_ok = 1'b0;
            tick(1);
        end
        check("timeout_pulses", pulses, 1);
        check("timeout_pos", pos, HMAX);
        check("timeout_id", {31'd0, timeout_id}, 32'd1);
        check("timeout_ack_held", {31'd0, ack_ok}, 32'd1);
        req = 2'b00;
        tick(1);
        wait_idle(2);
        check("timeout_id_kept", {31'd0, timeout_id}, 32'd1);
        tick(2);

        // Reset in the middle of a hold, request kept high.
        k = edge_n;
        push(1'b0, k + 4, k + 4);
        req = 2'b01;
        wait_ack(1'b0, 8);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("rst_hold_ack", {30'd0, ack}, 32'd0);
        check("rst_hold_mx_x", {30'd0, mx_x}, 32'd0);
        check("rst_hold_busy", {31'd0, busy}, 32'd0);
        check("rst_hold_timeout", {31'd0, timeout}, 32'd0);
        check("rst_hold_timeout_id", {31'd0, timeout_id}, 32'd0);
        rst = 1'b0;
        k = edge_n;
        push(1'b0, k + 4, k + 4);
        wait_ack(1'b0, 8);
        tick(1);
        req = 2'b00;
        tick(1);
        wait_idle(2);
        tick(2);

        // Random transactions, optionally with a contender arriving during the hold.
        for (int it = 0; it < 12; it++) begin
            c = 1'($urandom_range(0, 1));
            contend = 1'($urandom_range(0, 1));
            h = $urandom_range(1, 8);
            k = edge_n;
            push(c, k + 4, k + 4);
            req[c] = 1'b1;
            wait_ack(c, 8);
            if (contend) begin
                tick($urandom_range(0, 3));
                req[~c] = 1'b1;
            end
            tick(h);
            if (contend) begin
                k = edge_n;
                push(~c, k + 1 + 2 + SETTLE, k + 1 + 2 + SETTLE + 3);
            end
            req[c] = 1'b0;
            if (contend) begin
                wait_ack(~c, 12);
                tick($urandom_range(1, 6));
                req[~c] = 1'b0;
            end
            tick(1);
            wait_idle(2);
            tick(2);
        end

        tick(2);
        check("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
